exc_pc_sequencer: RTL and testbench

- Multi-cycle controller that owns the PCSource select and PC write-enable during exception entry and return-from-exception.
- Sits between the main control FSM and the PCSource mux / EPC register.
- In normal operation it forwards the main FSM's PC controls unchanged.
- On an exception it:
  - saves PC-4 into EPC,
  - reads the handler byte from the vector address,
  - loads PC from the sign-extended byte (PCSource=11).
- On RTE it loads PC from EPC (PCSource=01).

---
 rtl/exc_pc_sequencer_pkg.sv | 15 +
 rtl/exc_pc_sequencer_cause_encoder.sv | 25 ++
 rtl/exc_pc_sequencer.sv | 122 ++++++++++++
 tb/tb_exc_pc_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/exc_pc_sequencer_pkg.sv
// exc_pc_sequencer_pkg: shared state encoding, PCSource selects, cause codes and default vectors
package exc_pc_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, SAVE_EPC, VEC_RD, LOAD_PC, RTE} seqState_e;
  localparam logic [1:0] PCS_SHIFT = 2'b00;
  localparam logic [1:0] PCS_EPC = 2'b01;
  localparam logic [1:0] PCS_ALUOUT = 2'b10;
  localparam logic [1:0] PCS_SE8 = 2'b11;
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_OPCODE = 2'b01;
  localparam logic [1:0] CAUSE_OVF = 2'b10;
  localparam logic [1:0] CAUSE_DIV0 = 2'b11;
  localparam logic [31:0] DEF_VEC_OPCODE = 32'd253;
  localparam logic [31:0] DEF_VEC_OVF = 32'd254;
  localparam logic [31:0] DEF_VEC_DIV0 = 32'd255;
endpackage

// File: rtl/exc_pc_sequencer_cause_encoder.sv
// exc_cause_encoder: priority-encodes exception requests and maps a cause to its vector address
module exc_cause_encoder
  import exc_pc_sequencer_pkg::*;
#(
  parameter logic [31:0] VEC_OPCODE = DEF_VEC_OPCODE,
  parameter logic [31:0] VEC_OVF = DEF_VEC_OVF,
  parameter logic [31:0] VEC_DIV0 = DEF_VEC_DIV0
) (
  input  logic        excOpcode,
  input  logic        excOvf,
  input  logic        excDiv0,
  input  logic [1:0]  causeSel,
  output logic        anyExc,
  output logic [1:0]  cause,
  output logic [31:0] vector
);
  // opcode beats overflow beats divide-by-zero; vector follows the latched cause
  always_comb begin
    anyExc = excOpcode | excOvf | excDiv0;
    cause = excOpcode ? CAUSE_OPCODE : excOvf ? CAUSE_OVF : excDiv0 ? CAUSE_DIV0 : CAUSE_NONE;
    vector = (causeSel == CAUSE_OPCODE) ? VEC_OPCODE :
             (causeSel == CAUSE_OVF) ? VEC_OVF :
             (causeSel == CAUSE_DIV0) ? VEC_DIV0 : 32'd0;
  end
endmodule

// File: rtl/exc_pc_sequencer.sv
// exc_pc_sequencer: owns PCSource/PC write during exception entry and return-from-exception
module exc_pc_sequencer
  import exc_pc_sequencer_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2,
  parameter logic [31:0] VEC_OPCODE = DEF_VEC_OPCODE,
  parameter logic [31:0] VEC_OVF = DEF_VEC_OVF,
  parameter logic [31:0] VEC_DIV0 = DEF_VEC_DIV0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  input  logic        rte_req,
  input  logic [1:0]  main_pc_source,
  input  logic        main_pc_write,
  output logic [1:0]  pc_source,
  output logic        pc_write,
  output logic        epc_write,
  output logic        alu_pc_minus4,
  output logic        mem_read,
  output logic [31:0] mem_addr_exc,
  output logic        mem_addr_sel,
  output logic        busy,
  output logic [1:0]  exc_cause,
  output logic        exc_done
);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  seqState_e state, nextState;
  logic [CW-1:0] counter, nextCounter;
  logic anyExc;
  logic [1:0] encCause;
  logic [31:0] vector;
  exc_cause_encoder #(
    .VEC_OPCODE(VEC_OPCODE),
    .VEC_OVF(VEC_OVF),
    .VEC_DIV0(VEC_DIV0)
  ) u_enc (
    .excOpcode(exc_opcode),
    .excOvf(exc_ovf),
    .excDiv0(exc_div0),
    .causeSel(exc_cause),
    .anyExc(anyExc),
    .cause(encCause),
    .vector(vector)
  );
  // state, read-wait counter and latched cause; cause clears on reset or RTE
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      counter <= '0;
      exc_cause <= CAUSE_NONE;
    end else begin
      state <= nextState;
      counter <= nextCounter;
      if (state == IDLE && anyExc) exc_cause <= encCause;
      else if (state == RTE) exc_cause <= CAUSE_NONE;
    end
  end
  // next state and per-state controls; everything is forced low while reset is held
  always_comb begin
    nextState = state;
    nextCounter = counter;
    pc_source = PCS_SHIFT;
    pc_write = 1'b0;
    epc_write = 1'b0;
    alu_pc_minus4 = 1'b0;
    mem_read = 1'b0;
    mem_addr_exc = 32'd0;
    mem_addr_sel = 1'b0;
    busy = 1'b0;
    exc_done = 1'b0;
    case (state)
      IDLE: begin
        pc_source = main_pc_source;
        pc_write = main_pc_write & ~anyExc;
        nextState = anyExc ? SAVE_EPC : rte_req ? RTE : IDLE;
      end
      SAVE_EPC: begin
        alu_pc_minus4 = 1'b1;
        epc_write = 1'b1;
        busy = 1'b1;
        nextState = VEC_RD;
        nextCounter = CW'(MEM_LATENCY - 1);
      end
      VEC_RD: begin
        mem_read = 1'b1;
        mem_addr_sel = 1'b1;
        mem_addr_exc = vector;
        busy = 1'b1;
        nextState = (counter == '0) ? LOAD_PC : VEC_RD;
        nextCounter = (counter == '0) ? counter : counter - CW'(1);
      end
      LOAD_PC: begin
        pc_source = PCS_SE8;
        pc_write = 1'b1;
        exc_done = 1'b1;
        busy = 1'b1;
        nextState = IDLE;
      end
      RTE: begin
        pc_source = PCS_EPC;
        pc_write = 1'b1;
        busy = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    if (reset) begin
      pc_source = PCS_SHIFT;
      pc_write = 1'b0;
      epc_write = 1'b0;
      alu_pc_minus4 = 1'b0;
      mem_read = 1'b0;
      mem_addr_exc = 32'd0;
      mem_addr_sel = 1'b0;
      busy = 1'b0;
      exc_done = 1'b0;
    end
  end
endmodule

// File: tb/tb_exc_pc_sequencer.sv
// tb_exc_pc_sequencer: directed and random checks against a schedule-based reference model
module tb_exc_pc_sequencer;
  localparam int ML = 2;
  typedef struct packed {
    logic [1:0] pcs;
    logic pcw;
    logic epcw;
    logic m4;
    logic mrd;
    logic sel;
    logic [31:0] addr;
    logic busy;
    logic done;
  } outs_t;
  logic clk = 1'b0;
  logic reset, exc_opcode, exc_ovf, exc_div0, rte_req, main_pc_write;
  logic [1:0] main_pc_source;
  logic [1:0] pc_source, exc_cause;
  logic pc_write, epc_write, alu_pc_minus4, mem_read, mem_addr_sel, busy, exc_done;
  logic [31:0] mem_addr_exc;
  int checks = 0;
  int errors = 0;
  outs_t plan[$];
  logic [1:0] mCause = 2'b00;
  exc_pc_sequencer #(.MEM_LATENCY(ML)) dut (
    .clk(clk),
    .reset(reset),
    .exc_opcode(exc_opcode),
    .exc_ovf(exc_ovf),
    .exc_div0(exc_div0),
    .rte_req(rte_req),
    .main_pc_source(main_pc_source),
    .main_pc_write(main_pc_write),
    .pc_source(pc_source),
    .pc_write(pc_write),
    .epc_write(epc_write),
    .alu_pc_minus4(alu_pc_minus4),
    .mem_read(mem_read),
    .mem_addr_exc(mem_addr_exc),
    .mem_addr_sel(mem_addr_sel),
    .busy(busy),
    .exc_cause(exc_cause),
    .exc_done(exc_done)
  );
  always #5 clk = ~clk;
  task automatic setIn(input logic op, input logic ov, input logic dz, input logic rt,
                       input logic [1:0] mps, input logic mpw, input logic rs);
    exc_opcode = op;
    exc_ovf = ov;
    exc_div0 = dz;
    rte_req = rt;
    main_pc_source = mps;
    main_pc_write = mpw;
    reset = rs;
  endtask
  function automatic outs_t rec(input logic [1:0] pcs, input logic pcw, input logic epcw,
                                input logic m4, input logic mrd, input logic [31:0] addr,
                                input logic done);
    outs_t r;
    r.pcs = pcs;
    r.pcw = pcw;
    r.epcw = epcw;
    r.m4 = m4;
    r.mrd = mrd;
    r.sel = mrd;
    r.addr = addr;
    r.busy = 1'b1;
    r.done = done;
    return r;
  endfunction
  task automatic step(input string tag);
    outs_t exp, obs;
    logic anyExc;
    logic [1:0] c;
    outs_t popped;
    @(negedge clk);
    anyExc = exc_opcode | exc_ovf | exc_div0;
    exp = '0;
    if (!reset) begin
      if (plan.size() != 0) exp = plan[0];
      else begin
        exp.pcs = main_pc_source;
        exp.pcw = main_pc_write & ~anyExc;
      end
    end
    obs = {pc_source, pc_write, epc_write, alu_pc_minus4, mem_read, mem_addr_sel, mem_addr_exc, busy, exc_done};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s outputs obs=%h exp=%h", tag, obs, exp);
    end
    checks++;
    assert (exc_cause === mCause) else begin
      errors++;
      $error("FAIL %s exc_cause obs=%b exp=%b", tag, exc_cause, mCause);
    end
    @(posedge clk);
    if (reset) begin
      plan.delete();
      mCause = 2'b00;
    end else if (plan.size() != 0) begin
      popped = plan.pop_front();
      if (popped.pcs == 2'b01 && popped.pcw) mCause = 2'b00;
    end else if (anyExc) begin
      c = exc_opcode ? 2'b01 : exc_ovf ? 2'b10 : 2'b11;
      mCause = c;
      plan.push_back(rec(2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0));
      for (int i = 0; i < ML; i++) plan.push_back(rec(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'd252 + 32'(c), 1'b0));
      plan.push_back(rec(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1));
    end else if (rte_req) begin
      plan.push_back(rec(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
    end
    #1;
  endtask
  initial begin
    setIn(0, 0, 0, 0, 2'b10, 1, 1);
    step("reset0");
    step("reset1");
    setIn(0, 0, 0, 0, 2'b10, 1, 0);
    repeat (3) step("passthru");
    setIn(0, 0, 0, 0, 2'b00, 0, 0);
    step("passthru_zero");
    setIn(0, 1, 0, 0, 2'b10, 1, 0);
    step("ovf_detect");
    setIn(0, 0, 0, 0, 2'b10, 1, 0);
    step("ovf_save");
    step("ovf_rd0");
    step("ovf_rd1");
    step("ovf_load");
    step("ovf_idle");
    setIn(1, 0, 1, 1, 2'b01, 1, 0);
    step("prio_detect");
    setIn(0, 0, 0, 0, 2'b00, 0, 0);
    repeat (5) step("prio_seq");
    setIn(0, 0, 0, 1, 2'b10, 0, 0);
    step("rte_detect");
    setIn(0, 0, 0, 0, 2'b00, 0, 0);
    step("rte_load");
    step("rte_idle");
    setIn(0, 1, 0, 0, 2'b00, 0, 0);
    step("busy_detect");
    setIn(0, 0, 0, 0, 2'b00, 0, 0);
    step("busy_save");
    setIn(0, 0, 1, 1, 2'b10, 1, 0);
    step("busy_rd0");
    step("busy_rd1");
    setIn(0, 0, 0, 0, 2'b00, 0, 0);
    repeat (3) step("busy_tail");
    setIn(0, 0, 1, 0, 2'b00, 0, 0);
    step("rst_detect");
    setIn(0, 0, 0, 0, 2'b00, 0, 0);
    step("rst_save");
    setIn(0, 0, 0, 0, 2'b11, 1, 1);
    step("rst_mid");
    setIn(0, 0, 0, 0, 2'b00, 0, 0);
    repeat (6) step("rst_after");
    repeat (3000) begin
      setIn($urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0,
            $urandom_range(5) == 0, 2'($urandom), 1'($urandom), $urandom_range(63) == 0);
      step("random");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
